// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the memory-access stage.
// Holds the datapath width, state encodings and the default ack-wait limit.
package mem_access_stage_pkg;

    localparam int WORD_W             = 64;
    localparam int TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_e;

    function automatic logic take_branch(input logic branch,
                                         input logic zero,
                                         input logic uncond_branch);
        return (branch & zero) | uncond_branch;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Ack-wait watchdog: counts ACCESS cycles without ack and flags expiry.
// Instantiated by mem_access_stage only when MEM_TIMEOUT_EN is defined.
module mem_watchdog
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (active && !ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that would complete the TIMEOUT_CYCLES-th ackless cycle expires; an ack there wins.
    assign expired = active && !ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: LDUR/STUR over a req/ack port, branch resolution, one writeback beat.
// Optional ack timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WORD           = WORD_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] write_data,
    input  logic [WORD-1:0] branch_target,
    input  logic            zero,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic            mem_to_reg,
    input  logic            reg_write,
    input  logic [4:0]      rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [WORD-1:0] dmem_addr,
    output logic [WORD-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [WORD-1:0] dmem_rdata,
    output logic            pc_src,
    output logic [WORD-1:0] pc_target,
    output logic            wb_valid,
    output logic [WORD-1:0] wb_data,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            wb_err
);

    mem_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic [4:0]      rd_q, rd_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic            pc_src_q, pc_src_d;
    logic [WORD-1:0] pc_target_q, pc_target_d;
    logic            wb_valid_q, wb_valid_d;
    logic [WORD-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic            wb_err_q, wb_err_d;
    logic            is_mem_op;
    logic            timeout;

    assign is_mem_op = mem_read | mem_write;

`ifdef MEM_TIMEOUT_EN
    mem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  ((state_q == MEM_IDLE) && in_valid && is_mem_op),
        .active (state_q == MEM_ACCESS),
        .ack    (dmem_ack),
        .expired(timeout)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_d           = rd_q;
        reg_write_d    = reg_write_q;
        mem_to_reg_d   = mem_to_reg_q;
        pc_src_d       = 1'b0;
        pc_target_d    = pc_target_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_rd_d        = wb_rd_q;
        wb_reg_write_d = wb_reg_write_q;
        wb_err_d       = 1'b0;
        case (state_q)
            MEM_IDLE: begin
                if (in_valid) begin
                    if (take_branch(branch, zero, uncond_branch)) begin
                        pc_src_d    = 1'b1;
                        pc_target_d = branch_target;
                    end
                    // A load wins when both mem_read and mem_write are set.
                    if (is_mem_op) begin
                        state_d      = MEM_ACCESS;
                        req_d        = 1'b1;
                        we_d         = mem_write & ~mem_read;
                        addr_d       = alu_result;
                        wdata_d      = write_data;
                        rd_d         = rd;
                        reg_write_d  = reg_write;
                        mem_to_reg_d = mem_to_reg;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = alu_result;
                        wb_rd_d        = rd;
                        wb_reg_write_d = reg_write;
                    end
                end
            end
            MEM_ACCESS: begin
                if (dmem_ack) begin
                    state_d        = MEM_IDLE;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_data_d      = we_q ? addr_q : dmem_rdata;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = reg_write_q & ~we_q;
                end else if (timeout) begin
                    state_d        = MEM_IDLE;
                    req_d          = 1'b0;
                    wb_valid_d     = 1'b1;
                    wb_err_d       = 1'b1;
                    wb_data_d      = '0;
                    wb_rd_d        = rd_q;
                    wb_reg_write_d = 1'b0;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= MEM_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            reg_write_q    <= 1'b0;
            mem_to_reg_q   <= 1'b0;
            pc_src_q       <= 1'b0;
            pc_target_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            wb_err_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rd_q           <= rd_d;
            reg_write_q    <= reg_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            pc_src_q       <= pc_src_d;
            pc_target_q    <= pc_target_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_rd_q        <= wb_rd_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_err_q       <= wb_err_d;
        end
    end

    // Load data always comes from dmem_rdata, so the latched mem_to_reg is kept only for visibility.
    logic unused_mem_to_reg;
    assign unused_mem_to_reg = mem_to_reg_q;

    assign in_ready     = (state_q == MEM_IDLE);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_wdata   = wdata_q;
    assign pc_src       = pc_src_q;
    assign pc_target    = pc_target_q;
    assign wb_valid     = wb_valid_q;
    assign wb_data      = wb_data_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a behavioural memory and instruction model.
// Define MEM_TIMEOUT_EN for both bench and RTL to exercise the ack timeout.
module tb_mem_access_stage;

    localparam int W  = 64;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic [W-1:0]  alu_result, write_data, branch_target;
    logic          zero, mem_read, mem_write, branch, uncond_branch, mem_to_reg, reg_write;
    logic [4:0]    rd;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [W-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic          pc_src;
    logic [W-1:0]  pc_target;
    logic          wb_valid, wb_reg_write, wb_err;
    logic [W-1:0]  wb_data;
    logic [4:0]    wb_rd;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] mem_model [logic [W-1:0]];

    typedef struct packed {
        logic         mem_read;
        logic         mem_write;
        logic         branch;
        logic         uncond;
        logic         zero;
        logic         reg_write;
        logic         mem_to_reg;
        logic [W-1:0] alu;
        logic [W-1:0] wdata;
        logic [W-1:0] target;
        logic [4:0]   rd;
    } op_t;

    mem_access_stage #(.WORD(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .write_data(write_data), .branch_target(branch_target),
        .zero(zero), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
        .uncond_branch(uncond_branch), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .pc_src(pc_src), .pc_target(pc_target),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory contents: last stored value, or a fixed pattern derived from the address.
    function automatic logic [W-1:0] mem_lookup(input logic [W-1:0] addr);
        if (mem_model.exists(addr)) return mem_model[addr];
        return addr ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    function automatic op_t make_op(input logic rd_en, input logic wr_en, input logic [W-1:0] alu,
                                    input logic [W-1:0] wdata, input logic [4:0] r, input logic rw);
        op_t o;
        o = '0;
        o.mem_read = rd_en; o.mem_write = wr_en; o.alu = alu; o.wdata = wdata;
        o.rd = r; o.reg_write = rw; o.mem_to_reg = rd_en;
        return o;
    endfunction

    task automatic drive_op(input op_t o);
        in_valid = 1'b1; alu_result = o.alu; write_data = o.wdata; branch_target = o.target;
        zero = o.zero; mem_read = o.mem_read; mem_write = o.mem_write; branch = o.branch;
        uncond_branch = o.uncond; mem_to_reg = o.mem_to_reg; reg_write = o.reg_write; rd = o.rd;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; uncond_branch = 1'b0;
        zero = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
        alu_result = {$urandom, $urandom}; write_data = {$urandom, $urandom};
        branch_target = {$urandom, $urandom}; rd = 5'($urandom);
    endtask

    // One instruction through the stage; expectations come from the ISA-level meaning of the op.
    task automatic run_op(input string nm, input op_t o, input int ack_delay);
        logic         is_mem, is_load, take;
        logic [W-1:0] exp_data;
        logic         exp_rw;
        is_mem  = o.mem_read | o.mem_write;
        is_load = o.mem_read;
        take    = (o.branch & o.zero) | o.uncond;
        exp_data = o.alu;
        exp_rw   = o.reg_write;
        if (is_load) exp_data = mem_lookup(o.alu);
        else if (is_mem) exp_rw = 1'b0;

        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL %s ready_pre: got %0b want 1", nm, in_ready); else passed++;
        drive_op(o);
        step();
        drive_idle();
        checks++; if (pc_src !== take) $display("[TB] FAIL %s pc_src: got %0b want %0b", nm, pc_src, take); else passed++;
        if (take) begin
            checks++; if (pc_target !== o.target) $display("[TB] FAIL %s pc_target: got %h want %h", nm, pc_target, o.target); else passed++;
        end
        if (is_mem) begin
            checks++; if (dmem_req !== 1'b1) $display("[TB] FAIL %s req_rise: got %0b want 1", nm, dmem_req); else passed++;
            checks++; if (dmem_we !== !is_load) $display("[TB] FAIL %s we: got %0b want %0b", nm, dmem_we, !is_load); else passed++;
            checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL %s early_wb: got %0b want 0", nm, wb_valid); else passed++;
            for (int i = 0; i <= ack_delay; i++) begin
                checks++; if (dmem_addr !== o.alu) $display("[TB] FAIL %s addr_stable: got %h want %h", nm, dmem_addr, o.alu); else passed++;
                checks++; if (dmem_wdata !== o.wdata) $display("[TB] FAIL %s wdata_stable: got %h want %h", nm, dmem_wdata, o.wdata); else passed++;
                checks++; if (in_ready !== 1'b0) $display("[TB] FAIL %s ready_busy: got %0b want 0", nm, in_ready); else passed++;
                dmem_ack   = (i == ack_delay);
                dmem_rdata = (i == ack_delay && is_load) ? exp_data : {$urandom, $urandom};
                step();
                if (i < ack_delay) begin
                    checks++; if (dmem_req !== 1'b1) $display("[TB] FAIL %s req_hold: got %0b want 1", nm, dmem_req); else passed++;
                    checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL %s wait_wb: got %0b want 0", nm, wb_valid); else passed++;
                end
            end
            dmem_ack = 1'b0;
            if (!is_load) mem_model[o.alu] = o.wdata;
            checks++; if (dmem_req !== 1'b0) $display("[TB] FAIL %s req_drop: got %0b want 0", nm, dmem_req); else passed++;
        end
        checks++; if (wb_valid !== 1'b1) $display("[TB] FAIL %s wb_valid: got %0b want 1", nm, wb_valid); else passed++;
        checks++; if (wb_data !== exp_data) $display("[TB] FAIL %s wb_data: got %h want %h", nm, wb_data, exp_data); else passed++;
        checks++; if (wb_rd !== o.rd) $display("[TB] FAIL %s wb_rd: got %0d want %0d", nm, wb_rd, o.rd); else passed++;
        checks++; if (wb_reg_write !== exp_rw) $display("[TB] FAIL %s wb_reg_write: got %0b want %0b", nm, wb_reg_write, exp_rw); else passed++;
        checks++; if (wb_err !== 1'b0) $display("[TB] FAIL %s wb_err: got %0b want 0", nm, wb_err); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL %s ready_post: got %0b want 1", nm, in_ready); else passed++;
        step();
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL %s wb_pulse: got %0b want 0", nm, wb_valid); else passed++;
        checks++; if (pc_src !== 1'b0) $display("[TB] FAIL %s pc_pulse: got %0b want 0", nm, pc_src); else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        drive_idle();
        step(); step();
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst in_ready: got %0b want 1", in_ready); else passed++;
        checks++; if ({dmem_req, dmem_we, pc_src, wb_valid, wb_reg_write, wb_err} !== 6'b0)
            $display("[TB] FAIL rst ctrl: got %b want 000000", {dmem_req, dmem_we, pc_src, wb_valid, wb_reg_write, wb_err}); else passed++;
        checks++; if ({dmem_addr, dmem_wdata, pc_target, wb_data} !== '0)
            $display("[TB] FAIL rst data: got %h %h %h %h want 0", dmem_addr, dmem_wdata, pc_target, wb_data); else passed++;
        checks++; if (wb_rd !== 5'd0) $display("[TB] FAIL rst wb_rd: got %0d want 0", wb_rd); else passed++;
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) $display("[TB] FAIL rst release: got ready=%0b wb=%0b want 1/0", in_ready, wb_valid); else passed++;
    endtask

    task automatic test_reset_in_access();
        drive_op(make_op(1'b1, 1'b0, 64'h200, 64'h0, 5'd6, 1'b1));
        step();
        drive_idle();
        checks++; if (dmem_req !== 1'b1) $display("[TB] FAIL rst_acc req_before: got %0b want 1", dmem_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) $display("[TB] FAIL rst_acc req_async: got %0b want 0", dmem_req); else passed++;
        step();
        rst_n = 1'b1;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL rst_acc in_ready: got %0b want 1", in_ready); else passed++;
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL rst_acc wb_valid: got %0b want 0", wb_valid); else passed++;
        checks++; if (dmem_req !== 1'b0) $display("[TB] FAIL rst_acc req_after: got %0b want 0", dmem_req); else passed++;
    endtask

    task automatic test_alu_back_to_back();
        drive_op(make_op(1'b0, 1'b0, 64'h2A, 64'h0, 5'd3, 1'b1));
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h2A || wb_rd !== 5'd3 || wb_reg_write !== 1'b1)
                $display("[TB] FAIL b2b beat%0d: got v=%0b d=%h rd=%0d rw=%0b want 1/2a/3/1", i, wb_valid, wb_data, wb_rd, wb_reg_write); else passed++;
            checks++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b ready%0d: got %0b want 1", i, in_ready); else passed++;
        end
        drive_idle();
        step();
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL b2b end: got %0b want 0", wb_valid); else passed++;
    endtask

    task automatic test_load();
        mem_model[64'h80] = 64'hDEAD_BEEF;
        drive_op(make_op(1'b1, 1'b0, 64'h80, 64'h0, 5'd9, 1'b1));
        step();
        drive_op(make_op(1'b0, 1'b0, 64'h55, 64'h0, 5'd7, 1'b1));
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 64'h80)
                $display("[TB] FAIL load wait%0d: got ready=%0b req=%0b addr=%h want 0/1/80", i, in_ready, dmem_req, dmem_addr); else passed++;
            dmem_ack   = (i == 2);
            dmem_rdata = (i == 2) ? 64'hDEAD_BEEF : 64'h0;
            step();
            if (i < 2) begin
                checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL load early%0d: got %0b want 0", i, wb_valid); else passed++;
            end
        end
        dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 64'hDEAD_BEEF || wb_reg_write !== 1'b1 || wb_rd !== 5'd9)
            $display("[TB] FAIL load wb: got v=%0b d=%h rw=%0b rd=%0d want 1/deadbeef/1/9", wb_valid, wb_data, wb_reg_write, wb_rd); else passed++;
        checks++; if (in_ready !== 1'b1 || dmem_req !== 1'b0) $display("[TB] FAIL load done: got ready=%0b req=%0b want 1/0", in_ready, dmem_req); else passed++;
        step();
        drive_idle();
        checks++; if (wb_valid !== 1'b1 || wb_data !== 64'h55 || wb_rd !== 5'd7)
            $display("[TB] FAIL load held: got v=%0b d=%h rd=%0d want 1/55/7", wb_valid, wb_data, wb_rd); else passed++;
        step();
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL load tail: got %0b want 0", wb_valid); else passed++;
    endtask

    task automatic test_store();
        run_op("store", make_op(1'b0, 1'b1, 64'h40, 64'h1234, 5'd2, 1'b1), 0);
        run_op("load_after_store", make_op(1'b1, 1'b0, 64'h40, 64'h0, 5'd5, 1'b1), 1);
        run_op("both_is_load", make_op(1'b1, 1'b1, 64'h40, 64'hFFFF, 5'd8, 1'b1), 2);
    endtask

    task automatic test_branch();
        op_t o;
        logic [2:0] tbl [3];
        tbl[0] = 3'b110; tbl[1] = 3'b100; tbl[2] = 3'b001;
        for (int i = 0; i < 3; i++) begin
            o = make_op(1'b0, 1'b0, {$urandom, $urandom}, 64'h0, 5'd0, 1'b0);
            o.branch = tbl[i][2]; o.zero = tbl[i][1]; o.uncond = tbl[i][0];
            o.target = 64'h100 + 64'(i * 16);
            run_op("branch", o, 0);
        end
    endtask

    task automatic test_ack_idle();
        drive_idle();
        dmem_ack = 1'b1; dmem_rdata = 64'h1111;
        step(); step();
        dmem_ack = 1'b0;
        checks++; if (wb_valid !== 1'b0 || dmem_req !== 1'b0 || in_ready !== 1'b1)
            $display("[TB] FAIL ack_idle: got wb=%0b req=%0b ready=%0b want 0/0/1", wb_valid, dmem_req, in_ready); else passed++;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        drive_op(make_op(1'b1, 1'b0, 64'h10, 64'h0, 5'd4, 1'b1));
        step();
        drive_idle();
        dmem_ack = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            step();
            checks++; if (dmem_req !== 1'b1 || wb_valid !== 1'b0) $display("[TB] FAIL to wait%0d: got req=%0b wb=%0b want 1/0", i, dmem_req, wb_valid); else passed++;
        end
        step();
        checks++; if (dmem_req !== 1'b0 || wb_valid !== 1'b1 || wb_err !== 1'b1)
            $display("[TB] FAIL to fire: got req=%0b wb=%0b err=%0b want 0/1/1", dmem_req, wb_valid, wb_err); else passed++;
        checks++; if (wb_reg_write !== 1'b0 || wb_data !== '0 || in_ready !== 1'b1)
            $display("[TB] FAIL to data: got rw=%0b d=%h ready=%0b want 0/0/1", wb_reg_write, wb_data, in_ready); else passed++;
        step();
        checks++; if (wb_err !== 1'b0) $display("[TB] FAIL to pulse: got %0b want 0", wb_err); else passed++;
        run_op("ack_at_limit", make_op(1'b1, 1'b0, 64'h18, 64'h0, 5'd4, 1'b1), TO - 1);
    endtask
`endif

    task automatic test_random();
        op_t o;
        int  kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            o = make_op(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 1'($urandom));
            o.target = {$urandom, $urandom};
            if (kind == 1 || kind == 2) o.alu = 64'({$urandom_range(0, 7), 3'b000});
            if (kind == 1) begin
                o.mem_read = 1'b1; o.mem_to_reg = 1'b1; o.mem_write = ($urandom_range(0, 3) == 0);
            end
            if (kind == 2) o.mem_write = 1'b1;
            if (kind == 3) begin
                o.branch = 1'($urandom); o.zero = 1'($urandom); o.uncond = 1'($urandom);
                o.reg_write = 1'b0;
            end
            run_op("random", o, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_reset_in_access();
        test_alu_back_to_back();
        test_load();
        test_store();
        test_branch();
        test_ack_idle();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage directly downstream of the execute stage. It consumes alu_result, store data, branch_target and zero from execute, and performs LDUR/STUR through a req/ack data-memory port. It resolves the branch decision (pc_src) and hands one registered writeback beat to the writeback stage. The stage applies backpressure to execute (in_ready) while a memory access is outstanding.

Parameters:
WORD, `WORD (64), datapath width from definitions.vh
TIMEOUT_CYCLES, 16, ack wait limit; used only with MEM_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute result valid this cycle
in_ready  out  1  stage can accept; transfer = in_valid & in_ready
alu_result  in  WORD  ALU result, also memory address
write_data  in  WORD  store data (read_data2 from execute)
branch_target  in  WORD  branch target from execute
zero  in  1  ALU zero flag
mem_read  in  1  load
mem_write  in  1  store
branch  in  1  conditional branch (CBZ)
uncond_branch  in  1  unconditional branch (B)
mem_to_reg  in  1  writeback selects memory data
reg_write  in  1  instruction writes rd
rd  in  5  destination register
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = store
dmem_addr  out  WORD  byte address
dmem_wdata  out  WORD  store data
dmem_ack  in  1  request complete; rdata valid for loads
dmem_rdata  in  WORD  load data
pc_src  out  1  1-cycle pulse: take branch
pc_target  out  WORD  target registered with pc_src
wb_valid  out  1  1-cycle writeback beat
wb_data  out  WORD  writeback value
wb_rd  out  5  writeback register
wb_reg_write  out  1  writeback enable
wb_err  out  1  access aborted (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset, async: state=IDLE. Outputs dmem_req, dmem_we, pc_src, wb_valid, wb_reg_write and wb_err go to 0. All data/address outputs go to 0. in_ready=1 after release.
- States: IDLE, ACCESS. in_ready = (state==IDLE).
- IDLE with a transfer and no memory op: at the next edge, wb_valid=1, wb_data=alu_result, wb_rd=rd, wb_reg_write=reg_write. Stay IDLE. Throughput is 1 per cycle.
- IDLE with a transfer and mem_read or mem_write: latch addr, wdata, we=mem_write & ~mem_read, rd, reg_write and mem_to_reg. Go to ACCESS. dmem_req is registered and rises the cycle after accept.
- mem_read & mem_write both set: the access is treated as a load.
- ACCESS: dmem_req=1 and addr/we/wdata stay stable until dmem_ack is sampled high. On ack:
  - wb_valid=1 next cycle.
  - wb_data = dmem_rdata for a load, or the latched addr for a store.
  - wb_reg_write = latched reg_write & ~we.
  - dmem_req=0 next cycle; return to IDLE.
- Minimum load latency: accept at edge N, ack sampled at edge N+1 at the earliest, wb_valid high in the cycle after edge N+1.
- dmem_ack while in IDLE is ignored.
- Branch: on any transfer, pc_src = (branch & zero) | uncond_branch, registered as a 1-cycle pulse with pc_target = branch_target. Branches never access memory. wb_reg_write for a branch = reg_write (normally 0).
- wb_valid, pc_src and wb_err are single-cycle pulses. The writeback stage always accepts.
- Reset asserted during ACCESS: dmem_req drops immediately and the outstanding result is discarded.

Optional Feature:
MEM_TIMEOUT_EN. When defined:
- A counter clears on entry to ACCESS and increments each cycle without ack.
- When it reaches TIMEOUT_CYCLES with no ack, the stage drops dmem_req, emits wb_valid=1, wb_err=1, wb_reg_write=0 and wb_data=0, then returns to IDLE.
- An ack on the same edge as the timeout wins; the access completes normally.

When not defined: no counter exists, wb_err is constant 0, and ACCESS waits indefinitely.

Decomposition:
- definitions.vh: WORD, the state encodings (MEM_IDLE, MEM_ACCESS) and the default TIMEOUT_CYCLES.
- One natural sub-module, mem_watchdog: counter plus timeout comparator, instantiated only under MEM_TIMEOUT_EN.

Test Plan:
1. Reset during ACCESS, with rst_n low mid-request -> dmem_req drops the same cycle; after release, state=IDLE, in_ready=1, no wb_valid.
2. ALU op with alu_result=0x2A, rd=3, reg_write=1 on 3 consecutive cycles -> 3 consecutive wb_valid beats, wb_data=0x2A, wb_rd=3; in_ready stays 1.
3. Load: addr 0x80, ack after 3 cycles with rdata 0xDEADBEEF -> in_ready=0 throughout; wb_valid once, wb_data=0xDEADBEEF, wb_reg_write=1. A second in_valid held during the wait is accepted only after the return to IDLE.
4. Store: addr 0x40, wdata 0x1234, ack on the first req cycle -> dmem_we=1 with addr/wdata stable while req high; wb_reg_write=0.
5. Branch: branch=1 with zero=1 and target 0x100 -> pc_src pulse and pc_target=0x100. branch=1 with zero=0 -> no pulse. uncond_branch=1 with zero=0 -> pulse.
6. (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4) Load with no ack -> after 4 cycles: req drops, wb_err=1, wb_reg_write=0. Repeat with ack on the 4th cycle -> normal completion, wb_err=0.
